// File: rtl/pipe_stage_reg.sv
// Generic pipeline-stage register with valid/ready on both sides.
// SKID=1: two-entry skid buffer, in_ready comes straight from a flop.
// SKID=0: single register, in_ready = !out_valid | out_ready.
// Also provides a synchronous flush and a saturating stall-cycle counter.
module pipe_stage_reg #(
   parameter int PAYLOAD_W = 73,
   parameter int SKID      = 1,
   parameter int CNT_W     = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [PAYLOAD_W-1:0] in_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [PAYLOAD_W-1:0] out_data,
   input  logic                 flush,
   output logic [1:0]           occupancy,
   output logic [CNT_W-1:0]     stall_cnt
);

   // The state encoding is the number of held entries.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_e;

   state_e               state_q, state_d;
   logic [PAYLOAD_W-1:0] main_q, main_d;
   logic [PAYLOAD_W-1:0] skid_q, skid_d;
   logic                 rdy_q, rdy_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 accept, drain;

   // The main register always drives the output side.
   assign out_valid = (state_q != EMPTY);
   assign out_data  = main_q;
   assign occupancy = state_q;
   assign stall_cnt = cnt_q;

   // With a skid entry, ready is registered so no out_ready->in_ready path exists.
   assign in_ready  = (SKID != 0) ? rdy_q : (!out_valid | out_ready);

   assign accept = in_valid & in_ready;
   assign drain  = out_valid & out_ready;

   // Next-state, data steering and registered ready.
   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush) begin
         // Data registers keep their old contents; only the valid state is killed.
         state_d = EMPTY;
      end else begin
         case (state_q)
            EMPTY: begin
               if (accept) begin
                  main_d  = in_data;
                  state_d = ONE;
               end
            end
            ONE: begin
               if (accept && drain) begin
                  main_d = in_data;
               end else if (accept) begin
                  // Only reachable with a skid entry; SKID=0 drops ready here.
                  if (SKID != 0) begin
                     skid_d  = in_data;
                     state_d = TWO;
                  end else begin
                     main_d = in_data;
                  end
               end else if (drain) begin
                  state_d = EMPTY;
               end
            end
            TWO: begin
               // No accept is possible here because in_ready is low.
               if (drain) begin
                  main_d  = skid_q;
                  state_d = ONE;
               end
            end
            default: state_d = EMPTY;
         endcase
      end
      rdy_d = (state_d != TWO);
   end

   // Saturating count of cycles where the downstream stalls a valid output.
   always_comb begin
      cnt_d = cnt_q;
      if (out_valid && !out_ready && (cnt_q != {CNT_W{1'b1}}))
         cnt_d = cnt_q + CNT_W'(1);
   end

   // State, data and counter registers; reset discards everything.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= EMPTY;
         main_q  <= '0;
         skid_q  <= '0;
         rdy_q   <= 1'b1;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
         rdy_q   <= rdy_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: three instances share one stimulus
// stream (SKID=1 default, SKID=0, SKID=1 with a 4-bit stall counter).
module tb_pipe_stage_reg;
   localparam int W = 73;

   logic         clk = 1'b0;
   logic         reset;
   logic         in_valid;
   logic [W-1:0] in_data;
   logic         out_ready;
   logic         flush;

   logic         s1_ir, s1_ov, s0_ir, s0_ov, c4_ir, c4_ov;
   logic [W-1:0] s1_od, s0_od, c4_od;
   logic [1:0]   s1_occ, s0_occ, c4_occ;
   logic [15:0]  s1_cnt, s0_cnt;
   logic [3:0]   c4_cnt;

   int nvec = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   pipe_stage_reg #(.PAYLOAD_W(W), .SKID(1), .CNT_W(16)) u_s1 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(s1_ir), .in_data(in_data),
      .out_valid(s1_ov), .out_ready(out_ready), .out_data(s1_od), .flush(flush),
      .occupancy(s1_occ), .stall_cnt(s1_cnt));

   pipe_stage_reg #(.PAYLOAD_W(W), .SKID(0), .CNT_W(16)) u_s0 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(s0_ir), .in_data(in_data),
      .out_valid(s0_ov), .out_ready(out_ready), .out_data(s0_od), .flush(flush),
      .occupancy(s0_occ), .stall_cnt(s0_cnt));

   pipe_stage_reg #(.PAYLOAD_W(W), .SKID(1), .CNT_W(4)) u_c4 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(c4_ir), .in_data(in_data),
      .out_valid(c4_ov), .out_ready(out_ready), .out_data(c4_od), .flush(flush),
      .occupancy(c4_occ), .stall_cnt(c4_cnt));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Synchronous-looking reset pulse placed between edges.
   task automatic do_reset();
      in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0;
      #2 reset = 1'b1;
      tick();
      #2 reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0;
      #1;
      nvec++; if (s1_ov !== 1'b0) begin nerr++; $display("FAIL rst_ov got %0h want 0", s1_ov); end
      nvec++; if (s1_od !== '0) begin nerr++; $display("FAIL rst_od got %0h want 0", s1_od); end
      nvec++; if (s1_occ !== 2'd0) begin nerr++; $display("FAIL rst_occ got %0d want 0", s1_occ); end
      nvec++; if (s1_cnt !== 16'd0) begin nerr++; $display("FAIL rst_cnt got %0d want 0", s1_cnt); end
      nvec++; if (s1_ir !== 1'b1) begin nerr++; $display("FAIL rst_ir got %0h want 1", s1_ir); end
      nvec++; if (s0_ir !== 1'b1) begin nerr++; $display("FAIL rst_s0_ir got %0h want 1", s0_ir); end
      tick();
      #2 reset = 1'b0;
   endtask

   task automatic test_reset_mid();
      do_reset();
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = W'(8'h0A); tick();
      in_data = W'(8'h0B); tick();
      in_valid = 1'b0;
      nvec++; if (s1_occ !== 2'd2) begin nerr++; $display("FAIL mid_fill_occ got %0d want 2", s1_occ); end
      nvec++; if (s1_cnt !== 16'd1) begin nerr++; $display("FAIL mid_fill_cnt got %0d want 1", s1_cnt); end
      #2 reset = 1'b1;
      #1;
      nvec++; if (s1_ov !== 1'b0) begin nerr++; $display("FAIL mid_ov got %0h want 0", s1_ov); end
      nvec++; if (s1_occ !== 2'd0) begin nerr++; $display("FAIL mid_occ got %0d want 0", s1_occ); end
      nvec++; if (s1_cnt !== 16'd0) begin nerr++; $display("FAIL mid_cnt got %0d want 0", s1_cnt); end
      nvec++; if (s1_od !== '0) begin nerr++; $display("FAIL mid_od got %0h want 0", s1_od); end
      tick();
      #2 reset = 1'b0;
      #1;
      nvec++; if (s1_ir !== 1'b1) begin nerr++; $display("FAIL mid_ir got %0h want 1", s1_ir); end
      in_valid = 1'b1; in_data = W'(8'h77); tick();
      in_valid = 1'b0;
      nvec++; if (s1_ov !== 1'b1 || s1_od !== W'(8'h77)) begin nerr++; $display("FAIL mid_post got v=%0h d=%0h want v=1 d=77", s1_ov, s1_od); end
   endtask

   task automatic test_streaming();
      do_reset();
      out_ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         in_valid = 1'b1; in_data = W'(i);
         tick();
         nvec++; if (s1_ov !== 1'b1 || s1_od !== W'(i)) begin nerr++; $display("FAIL stream_s1[%0d] got v=%0h d=%0h want v=1 d=%0h", i, s1_ov, s1_od, i); end
         nvec++; if (s0_ov !== 1'b1 || s0_od !== W'(i)) begin nerr++; $display("FAIL stream_s0[%0d] got v=%0h d=%0h want v=1 d=%0h", i, s0_ov, s0_od, i); end
         nvec++; if (s1_occ !== 2'd1) begin nerr++; $display("FAIL stream_occ[%0d] got %0d want 1", i, s1_occ); end
      end
      in_valid = 1'b0; tick();
      nvec++; if (s1_ov !== 1'b0) begin nerr++; $display("FAIL stream_end_ov got %0h want 0", s1_ov); end
      nvec++; if (s1_cnt !== 16'd0) begin nerr++; $display("FAIL stream_cnt got %0d want 0", s1_cnt); end
   endtask

   task automatic test_backpressure();
      do_reset();
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = W'(8'h11); tick();
      nvec++; if (s1_ir !== 1'b1 || s1_occ !== 2'd1) begin nerr++; $display("FAIL bp1 got ir=%0h occ=%0d want ir=1 occ=1", s1_ir, s1_occ); end
      in_data = W'(8'h22); tick();
      nvec++; if (s1_ir !== 1'b0 || s1_occ !== 2'd2) begin nerr++; $display("FAIL bp2 got ir=%0h occ=%0d want ir=0 occ=2", s1_ir, s1_occ); end
      in_data = W'(8'h33); tick();
      nvec++; if (s1_ir !== 1'b0 || s1_occ !== 2'd2 || s1_od !== W'(8'h11)) begin nerr++; $display("FAIL bp_hold got ir=%0h occ=%0d d=%0h want ir=0 occ=2 d=11", s1_ir, s1_occ, s1_od); end
      out_ready = 1'b1; tick();
      nvec++; if (s1_od !== W'(8'h22) || s1_occ !== 2'd1 || s1_ir !== 1'b1) begin nerr++; $display("FAIL bp_d2 got d=%0h occ=%0d ir=%0h want d=22 occ=1 ir=1", s1_od, s1_occ, s1_ir); end
      tick();
      in_valid = 1'b0;
      nvec++; if (s1_od !== W'(8'h33) || s1_ov !== 1'b1) begin nerr++; $display("FAIL bp_d3 got v=%0h d=%0h want v=1 d=33", s1_ov, s1_od); end
      tick();
      nvec++; if (s1_ov !== 1'b0 || s1_occ !== 2'd0) begin nerr++; $display("FAIL bp_empty got v=%0h occ=%0d want 0 0", s1_ov, s1_occ); end
      nvec++; if (s1_cnt !== 16'd2) begin nerr++; $display("FAIL bp_cnt got %0d want 2", s1_cnt); end
   endtask

   task automatic test_flush();
      do_reset();
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = W'(8'h01); tick();
      in_data = W'(8'h02); tick();
      flush = 1'b1; in_data = W'(8'h44); tick();
      flush = 1'b0; in_valid = 1'b0;
      nvec++; if (s1_ov !== 1'b0 || s1_occ !== 2'd0 || s1_ir !== 1'b1) begin nerr++; $display("FAIL fl_two got v=%0h occ=%0d ir=%0h want 0 0 1", s1_ov, s1_occ, s1_ir); end
      nvec++; if (s1_cnt !== 16'd2) begin nerr++; $display("FAIL fl_cnt got %0d want 2", s1_cnt); end
      in_valid = 1'b1; in_data = W'(8'h45); tick();
      nvec++; if (s1_ov !== 1'b1 || s1_od !== W'(8'h45)) begin nerr++; $display("FAIL fl_refill got v=%0h d=%0h want 1 45", s1_ov, s1_od); end
      // flush, accept and drain all on the same edge
      flush = 1'b1; in_data = W'(8'h46); out_ready = 1'b1; tick();
      flush = 1'b0; in_valid = 1'b0;
      nvec++; if (s1_ov !== 1'b0 || s1_occ !== 2'd0) begin nerr++; $display("FAIL fl_one got v=%0h occ=%0d want 0 0", s1_ov, s1_occ); end
      nvec++; if (s0_ov !== 1'b0) begin nerr++; $display("FAIL fl_s0 got v=%0h want 0", s0_ov); end
      tick(); tick();
      nvec++; if (s1_ov !== 1'b0) begin nerr++; $display("FAIL fl_ghost got v=%0h want 0", s1_ov); end
   endtask

   task automatic test_skid0();
      do_reset();
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = W'(8'h50); tick();
      nvec++; if (s0_ov !== 1'b1 || s0_od !== W'(8'h50)) begin nerr++; $display("FAIL s0_load got v=%0h d=%0h want 1 50", s0_ov, s0_od); end
      in_data = W'(8'h55); #1;
      nvec++; if (s0_ir !== 1'b0 || s0_occ !== 2'd1) begin nerr++; $display("FAIL s0_block got ir=%0h occ=%0d want 0 1", s0_ir, s0_occ); end
      out_ready = 1'b1; #1;
      nvec++; if (s0_ir !== 1'b1) begin nerr++; $display("FAIL s0_pass got ir=%0h want 1", s0_ir); end
      tick();
      in_valid = 1'b0;
      nvec++; if (s0_ov !== 1'b1 || s0_od !== W'(8'h55) || s0_occ !== 2'd1) begin nerr++; $display("FAIL s0_next got v=%0h d=%0h occ=%0d want 1 55 1", s0_ov, s0_od, s0_occ); end
      tick();
      nvec++; if (s0_ov !== 1'b0) begin nerr++; $display("FAIL s0_drain got v=%0h want 0", s0_ov); end
   endtask

   task automatic test_saturation();
      do_reset();
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = W'(8'h66); tick();
      in_valid = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         tick();
         nvec++; if (c4_cnt !== 4'((i > 15) ? 15 : i)) begin nerr++; $display("FAIL sat_c4[%0d] got %0d want %0d", i, c4_cnt, (i > 15) ? 15 : i); end
      end
      nvec++; if (s1_cnt !== 16'd20) begin nerr++; $display("FAIL sat_c16 got %0d want 20", s1_cnt); end
      nvec++; if (c4_ov !== 1'b1 || c4_od !== W'(8'h66)) begin nerr++; $display("FAIL sat_hold got v=%0h d=%0h want 1 66", c4_ov, c4_od); end
   endtask

   initial begin
      test_reset();
      test_reset_mid();
      test_streaming();
      test_backpressure();
      test_flush();
      test_skid0();
      test_saturation();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Generic parametrised pipeline-stage register that replaces the hand-written inter-stage latches (EX/MEM and similar). It carries one packed payload per valid slot and uses a valid/ready handshake on both sides, so upstream stalls and downstream back-pressure propagate without combinational ready paths. A synchronous flush inserts bubbles. A saturating stall counter supports performance debug.

Parameters:
PAYLOAD_W, 73, width of the packed payload (WB ctrl 2 + M ctrl 2 + ALUout 32 + store data 32 + dest reg 5).
SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single register with pass-through ready.
CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
in_valid  input  1  upstream stage holds a valid payload
in_ready  output  1  this stage accepts in_data this cycle
in_data  input  PAYLOAD_W  packed payload from the upstream stage
out_valid  output  1  out_data is valid
out_ready  input  1  downstream consumes out_data this cycle
out_data  output  PAYLOAD_W  packed payload to the downstream stage
flush  input  1  synchronous kill of all held entries (branch/exception)
occupancy  output  2  number of held entries (0..2; never exceeds 1 when SKID=0)
stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0, saturating

Behaviour:
- Transfers: accept = in_valid & in_ready; drain = out_valid & out_ready; both evaluated at the rising edge of clk.
- Reset (async, asserts immediately, independent of clk): out_valid=0, out_data=0, skid entry cleared, occupancy=0, stall_cnt=0. in_ready=1 while reset is asserted and on the first edge after release. Reset mid-transfer discards all entries. Entries accepted in the cycle reset asserts are lost.
- SKID=1 state machine, with the main register driving out_*:
  - EMPTY to ONE on accept.
  - ONE stays ONE on accept & drain; goes to TWO on accept & !drain (incoming data goes to the skid); goes to EMPTY on drain & !accept.
  - TWO to ONE on drain (the skid moves to main). accept is impossible in TWO.
  - in_ready is a register output: 1 in EMPTY/ONE, 0 in TWO. It has no combinational path from out_ready.
- SKID=0: single register. in_ready = !out_valid | out_ready (combinational). The main register loads on accept, and out_valid clears on drain & !accept.
- Latency: 1 cycle from accept to out_valid when the stage is empty. Order is strictly FIFO. No payload is dropped or duplicated except by flush or reset.
- flush: at the edge, all valid bits clear and the state goes to EMPTY. flush takes priority over a simultaneous accept, so that input is discarded. A simultaneous drain still completes. Data registers hold their old value, which is don't-care with out_valid=0. in_ready=1 on the next cycle.
- out_data is stable whenever out_valid=1 and out_ready=0.
- stall_cnt increments on each edge where out_valid & !out_ready, and saturates at 2^CNT_W-1. It is not cleared by flush.
- occupancy always equals the number of valid entries: EMPTY=0, ONE=1, TWO=2.

Test Plan:
- Reset mid-operation: fill to TWO with payloads 0x0A and 0x0B, then assert reset between edges -> out_valid, occupancy and stall_cnt go to 0 immediately, out_data=0; after release, in_ready=1.
- Streaming: in_valid=1 for 8 cycles with payloads 1..8 and out_ready=1 -> out_data shows 1..8 on consecutive cycles, 1 cycle behind the input; occupancy stays 1; stall_cnt=0.
- Back-pressure (SKID=1): send 0x11, 0x22, 0x33 back-to-back with out_ready=0 -> 0x11 in main, 0x22 in skid, in_ready=0 after the 2nd accept, 0x33 held upstream; then raise out_ready -> outputs are 0x11, 0x22, 0x33 in order, nothing lost, and stall_cnt equals the number of cycles out_ready was 0 while valid.
- Flush with accept: in TWO, assert flush with in_valid=1 and payload 0x44 -> next cycle out_valid=0, occupancy=0, in_ready=1, and 0x44 never appears.
- SKID=0 pass-through ready: out_valid=1, out_ready=1, in_valid=1 with 0x55 -> in_ready=1 in the same cycle and out_data=0x55 the next cycle.
- Counter saturation with CNT_W=4: hold out_valid=1, out_ready=0 for 20 cycles -> stall_cnt stops at 15.
